// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and MEM-stage access to one single-port synchronous RAM.
// Define MEM_ARB_RR_EN for round-robin conflict resolution; default is fixed MEM priority.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int WORD_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_if_req,
   input  logic [ADDR_WIDTH-1:0] in_if_addr,
   output logic                  out_if_gnt,
   output logic                  out_if_valid,
   output logic [WORD_WIDTH-1:0] out_if_word,
   input  logic                  in_mem_req,
   input  logic                  in_mem_we,
   input  logic [ADDR_WIDTH-1:0] in_mem_addr,
   input  logic [WORD_WIDTH-1:0] in_mem_wdata,
   output logic                  out_mem_gnt,
   output logic                  out_mem_valid,
   output logic [WORD_WIDTH-1:0] out_mem_word,
   output logic                  out_ram_en,
   output logic                  out_ram_we,
   output logic [ADDR_WIDTH-1:0] out_ram_addr,
   output logic [WORD_WIDTH-1:0] out_ram_wdata,
   input  logic [WORD_WIDTH-1:0] in_ram_rdata,
   output logic                  out_stall,
   output logic [CNT_WIDTH-1:0]  out_conflicts
);
   typedef enum logic [1:0] {RD_NONE, RD_IF, RD_MEM} owner_t;
   owner_t owner, owner_nxt;
   logic conflict, mem_first;
   logic [WORD_WIDTH-1:0] if_hold, mem_hold;

`ifdef MEM_ARB_RR_EN
   logic rr_ptr; // 0: MEM takes the next conflict
   always_ff @(posedge clock or negedge reset)
      if (!reset) rr_ptr <= 1'b0;
      else if (conflict) rr_ptr <= ~rr_ptr;
   assign mem_first = ~rr_ptr;
`else
   assign mem_first = 1'b1;
`endif

   // reset gates every request-derived output combinationally
   assign conflict      = reset & in_if_req & in_mem_req;
   assign out_stall     = conflict;
   assign out_mem_gnt   = reset & in_mem_req & (~in_if_req | mem_first);
   assign out_if_gnt    = reset & in_if_req & ~(in_mem_req & mem_first);
   assign out_ram_en    = out_if_gnt | out_mem_gnt;
   assign out_ram_we    = out_mem_gnt & in_mem_we;
   assign out_ram_addr  = out_mem_gnt ? in_mem_addr : in_if_addr;
   assign out_ram_wdata = out_ram_we ? in_mem_wdata : '0;

   always_comb begin
      owner_nxt = RD_NONE;
      owner_nxt = out_if_gnt ? RD_IF : (out_mem_gnt && !in_mem_we) ? RD_MEM : RD_NONE;
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) owner <= RD_NONE;
      else owner <= owner_nxt;

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         if_hold  <= '0;
         mem_hold <= '0;
      end else begin
         if (owner == RD_IF) if_hold <= in_ram_rdata;
         if (owner == RD_MEM) mem_hold <= in_ram_rdata;
      end

   always_ff @(posedge clock or negedge reset)
      if (!reset) out_conflicts <= '0;
      else if (conflict && !(&out_conflicts)) out_conflicts <= out_conflicts + 1'b1;

   // read data is live on the return cycle and held afterwards
   assign out_if_valid  = (owner == RD_IF);
   assign out_mem_valid = (owner == RD_MEM);
   assign out_if_word   = out_if_valid ? in_ram_rdata : if_hold;
   assign out_mem_word  = out_mem_valid ? in_ram_rdata : mem_hold;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, directed corner cases and random traffic against a cycle reference model.
module tb_mem_arbiter;
   localparam int AW = 12;
   localparam int WW = 16;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
   logic [AW-1:0] if_addr = '0, mem_addr = '0;
   logic [WW-1:0] mem_wdata = '0, ram_rdata;
   logic if_gnt, if_valid, mem_gnt, mem_valid, ram_en, ram_we, stall;
   logic [WW-1:0] if_word, mem_word, ram_wdata;
   logic [AW-1:0] ram_addr;
   logic [15:0] conflicts;
   logic if_gnt4, if_valid4, mem_gnt4, mem_valid4, ram_en4, ram_we4, stall4;
   logic [WW-1:0] if_word4, mem_word4, ram_wdata4;
   logic [AW-1:0] ram_addr4;
   logic [3:0] conflicts4;
   logic [WW-1:0] ram [0:(1<<AW)-1];
   int n_checks = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .in_if_req(if_req), .in_if_addr(if_addr),
      .out_if_gnt(if_gnt), .out_if_valid(if_valid), .out_if_word(if_word),
      .in_mem_req(mem_req), .in_mem_we(mem_we), .in_mem_addr(mem_addr), .in_mem_wdata(mem_wdata),
      .out_mem_gnt(mem_gnt), .out_mem_valid(mem_valid), .out_mem_word(mem_word),
      .out_ram_en(ram_en), .out_ram_we(ram_we), .out_ram_addr(ram_addr), .out_ram_wdata(ram_wdata),
      .in_ram_rdata(ram_rdata), .out_stall(stall), .out_conflicts(conflicts)
   );

   mem_arbiter #(.CNT_WIDTH(4)) dut4 (
      .clock(clock), .reset(reset),
      .in_if_req(if_req), .in_if_addr(if_addr),
      .out_if_gnt(if_gnt4), .out_if_valid(if_valid4), .out_if_word(if_word4),
      .in_mem_req(mem_req), .in_mem_we(mem_we), .in_mem_addr(mem_addr), .in_mem_wdata(mem_wdata),
      .out_mem_gnt(mem_gnt4), .out_mem_valid(mem_valid4), .out_mem_word(mem_word4),
      .out_ram_en(ram_en4), .out_ram_we(ram_we4), .out_ram_addr(ram_addr4), .out_ram_wdata(ram_wdata4),
      .in_ram_rdata(ram_rdata), .out_stall(stall4), .out_conflicts(conflicts4)
   );

   always @(posedge clock)
      if (ram_en) begin
         if (ram_we) ram[ram_addr] <= ram_wdata;
         else ram_rdata <= ram[ram_addr];
      end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // 0 = nobody, 1 = fetch, 2 = MEM
   function automatic int winner(input bit ir, input bit mr, input bit ptr);
      if (ir && mr) return (RR && ptr) ? 1 : 2;
      if (mr) return 2;
      if (ir) return 1;
      return 0;
   endfunction

   int m_pend, m_cnt, m_cnt4;
   bit m_ptr;
   logic [WW-1:0] m_pdata, m_ifw, m_memw;

   always @(posedge clock or negedge reset)
      if (!reset) begin
         m_pend = 0; m_cnt = 0; m_cnt4 = 0; m_ptr = 0;
         m_pdata = '0; m_ifw = '0; m_memw = '0;
      end else begin
         int w;
         w = winner(if_req, mem_req, m_ptr);
         if (m_pend == 1) m_ifw = m_pdata;
         if (m_pend == 2) m_memw = m_pdata;
         m_pend = 0;
         if (w == 1) begin m_pend = 1; m_pdata = ram[if_addr]; end
         else if (w == 2 && !mem_we) begin m_pend = 2; m_pdata = ram[mem_addr]; end
         if (if_req && mem_req) begin
            m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
            m_ptr  = !m_ptr;
         end
      end

   always @(negedge clock) begin
      int w;
      w = reset ? winner(if_req, mem_req, m_ptr) : 0;
      check("if_gnt", if_gnt, w == 1);
      check("mem_gnt", mem_gnt, w == 2);
      check("mem_gnt4", mem_gnt4, w == 2);
      check("stall", stall, reset && if_req && mem_req);
      check("ram_en", ram_en, w != 0);
      check("ram_we", ram_we, w == 2 && mem_we);
      if (w != 0) check("ram_addr", ram_addr, w == 2 ? mem_addr : if_addr);
      if (w == 2 && mem_we) check("ram_wdata", ram_wdata, mem_wdata);
      check("if_valid", if_valid, m_pend == 1);
      check("mem_valid", mem_valid, m_pend == 2);
      check("if_word", if_word, m_pend == 1 ? m_pdata : m_ifw);
      check("mem_word", mem_word, m_pend == 2 ? m_pdata : m_memw);
      check("conflicts", conflicts, m_cnt);
      check("conflicts4", conflicts4, m_cnt4);
   end

   task automatic drive(input bit ir, input logic [AW-1:0] ia, input bit mr, input bit we,
                        input logic [AW-1:0] ma, input logic [WW-1:0] wd);
      if_req = ir; if_addr = ia; mem_req = mr; mem_we = we; mem_addr = ma; mem_wdata = wd;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      drive(1, 12'h001, 1, 0, 12'h002, 16'h0);
      @(negedge clock);
      #1;
      check("rst_gnts", {if_gnt, mem_gnt, stall, ram_en}, 4'b0000);
      check("rst_valids", {if_valid, mem_valid}, 2'b00);
      check("rst_words", {if_word, mem_word}, 32'h0);
      check("rst_conflicts", conflicts, 16'h0);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clock);
      #1 reset = 1'b1;
      tick();
   endtask

   typedef struct {
      bit ir; logic [AW-1:0] ia; bit mr; bit we; logic [AW-1:0] ma; logic [WW-1:0] wd;
      bit e_ifg; bit e_memg; bit e_stall; bit e_we; bit e_ifv; bit e_memv;
   } vec_t;

   initial begin
      vec_t tbl[8];
      int exp_w[4];
      for (int i = 0; i < (1 << AW); i++) ram[i] = 16'($urandom);
      ram[12'h010] = 16'hA5A5;
      ram[12'h020] = 16'h0F0F;
      ram[12'h030] = 16'h5A5A;
      tbl[0] = '{1, 12'h010, 0, 0, 12'h000, 16'h0000, 1, 0, 0, 0, 0, 0};
      tbl[1] = '{0, 12'h000, 1, 0, 12'h030, 16'h0000, 0, 1, 0, 0, 1, 0};
      tbl[2] = '{0, 12'h000, 1, 1, 12'h050, 16'hBEEF, 0, 1, 0, 1, 0, 1};
      tbl[3] = '{0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 0, 0, 0, 0, 0};
      tbl[4] = '{1, 12'h020, 1, 0, 12'h030, 16'h0000, 0, 1, 1, 0, 0, 0};
      tbl[5] = '{1, 12'h020, 0, 0, 12'h000, 16'h0000, 1, 0, 0, 0, 0, 1};
      tbl[6] = '{0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 0, 0, 0, 1, 0};
      tbl[7] = '{0, 12'h000, 0, 0, 12'h000, 16'h0000, 0, 0, 0, 0, 0, 0};
      tick();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].ir, tbl[i].ia, tbl[i].mr, tbl[i].we, tbl[i].ma, tbl[i].wd);
         @(negedge clock);
         check($sformatf("vec%0d_if_gnt", i), if_gnt, tbl[i].e_ifg);
         check($sformatf("vec%0d_mem_gnt", i), mem_gnt, tbl[i].e_memg);
         check($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
         check($sformatf("vec%0d_ram_we", i), ram_we, tbl[i].e_we);
         check($sformatf("vec%0d_if_valid", i), if_valid, tbl[i].e_ifv);
         check($sformatf("vec%0d_mem_valid", i), mem_valid, tbl[i].e_memv);
         tick();
      end

      do_reset();
      drive(1, 12'h010, 0, 0, 0, 0);
      @(negedge clock);
      check("fetch_ram_addr", {ram_en, ram_we, ram_addr}, {2'b10, 12'h010});
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clock);
      check("fetch_valid", {if_valid, if_word}, {1'b1, 16'hA5A5});
      tick();
      @(negedge clock);
      check("fetch_held", {if_valid, if_word}, {1'b0, 16'hA5A5});
      tick();

      do_reset();
      drive(1, 12'h020, 1, 0, 12'h030, 0);
      @(negedge clock);
      check("conf_grants", {mem_gnt, if_gnt, stall}, 3'b101);
      tick();
      drive(1, 12'h020, 0, 0, 0, 0);
      @(negedge clock);
      check("conf_count", conflicts, 16'd1);
      check("conf_mem_ret", {mem_valid, mem_word}, {1'b1, 16'h5A5A});
      check("conf_if_next", if_gnt, 1'b1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clock);
      check("conf_if_ret", {if_valid, if_word}, {1'b1, 16'h0F0F});
      tick();

      drive(0, 0, 1, 1, 12'h040, 16'h1234);
      @(negedge clock);
      check("wr_ram", {ram_we, ram_addr, ram_wdata}, {1'b1, 12'h040, 16'h1234});
      tick();
      drive(0, 0, 1, 0, 12'h040, 0);
      @(negedge clock);
      check("wr_no_valid", mem_valid, 1'b0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clock);
      check("wr_readback", {mem_valid, mem_word}, {1'b1, 16'h1234});
      tick();

      do_reset();
      exp_w = RR ? '{2, 1, 2, 1} : '{2, 2, 2, 2};
      for (int i = 0; i < 4; i++) begin
         drive(1, 12'(i), 1, 0, 12'(i + 8), 0);
         @(negedge clock);
         check($sformatf("rr%0d_mem_gnt", i), mem_gnt, exp_w[i] == 2);
         check($sformatf("rr%0d_if_gnt", i), if_gnt, exp_w[i] == 1);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clock);
      check("rr_count", conflicts, 16'd4);
      tick();

      do_reset();
      drive(1, 12'h003, 1, 1, 12'h060, 16'h7777);
      tick();
      drive(1, 12'h010, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      #1;
      check("rst_mid_valid", {if_valid, mem_valid}, 2'b00);
      @(negedge clock);
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clock);
         check("rst_mid_after", {if_valid, mem_valid}, 2'b00);
         check("rst_mid_conf", conflicts, 16'd0);
      end
      tick();

      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1, 12'(i), 1, i[0], 12'(i + 100), 16'(i));
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clock);
      check("sat_conflicts4", conflicts4, 4'hF);
      check("sat_conflicts16", conflicts, 16'd20);
      tick();

      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)), 16'($urandom));
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, the memory word address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 16, the memory data width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, the conflict counter width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clock, input, 1, the rising-edge clock.
REQ-006 SHALL have port reset, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port in_if_req, input, 1, the fetch read request.
REQ-008 SHALL have port in_if_addr, input, ADDR_WIDTH, the fetch address.
REQ-009 SHALL have ports out_if_gnt, output, 1, and out_if_valid, output, 1: fetch grant and read data valid.
REQ-010 SHALL have port out_if_word, output, WORD_WIDTH, the fetch read data.
REQ-011 SHALL have ports in_mem_req, input, 1, and in_mem_we, input, 1: MEM-stage request and write enable.
REQ-012 SHALL have ports in_mem_addr, input, ADDR_WIDTH, and in_mem_wdata, input, WORD_WIDTH.
REQ-013 SHALL have ports out_mem_gnt, output, 1, out_mem_valid, output, 1, and out_mem_word, output, WORD_WIDTH.
REQ-014 SHALL have ports out_ram_en, output, 1, out_ram_we, output, 1, out_ram_addr, output, ADDR_WIDTH, and out_ram_wdata, output, WORD_WIDTH: the single-port synchronous RAM.
REQ-015 SHALL have port in_ram_rdata, input, WORD_WIDTH: RAM read data, valid one cycle after the read is issued.
REQ-016 SHALL have ports out_stall, output, 1 (a request was denied this cycle) and out_conflicts, output, CNT_WIDTH.

Function
REQ-017 SHALL grant at most one requester per cycle; the grants are combinational from the requests and the arbiter state.
REQ-018 SHALL drive the RAM in the grant cycle: out_ram_en=1, with addr/we/wdata taken from the winner; out_ram_we=0 for fetch.
REQ-019 SHALL register the read owner in state RD_NONE, RD_IF or RD_MEM at the grant edge; granted MEM writes leave RD_NONE.
REQ-020 SHALL, in the cycle after the grant, pulse the owner's valid for 1 cycle and drive its word from in_ram_rdata. Latency is exactly 1 cycle.
REQ-021 SHALL hold out_if_word and out_mem_word at their last captured value while the matching valid is low.
REQ-022 SHALL never assert out_mem_valid for writes.
REQ-023 SHALL, with no macro, give fixed priority: MEM wins a conflict and fetch is denied.
REQ-024 SHALL assert out_stall combinationally when both requests are high in the same cycle.
REQ-025 SHALL increment out_conflicts by 1 per conflict cycle, saturating at all-ones (no wrap).
REQ-026 SHALL accept back-to-back grants every cycle; a new read issued while a valid is being returned is legal.
REQ-027 SHALL, with no request, drive out_ram_en=0 and set the owner to RD_NONE at the next edge.

Reset
REQ-028 SHALL, on reset assertion, force immediately: owner RD_NONE, out_if_valid=0, out_mem_valid=0, out_if_word=0, out_mem_word=0, out_conflicts=0, RR pointer=MEM-first.
REQ-029 SHALL drop any outstanding read on reset mid-operation; no valid is produced after release.
REQ-030 SHALL gate out_ram_en, the grants and out_stall to 0 while reset is low.

Configuration
REQ-031 SHALL honour macro MEM_ARB_RR_EN: when defined, conflicts alternate winners through a 1-bit pointer that flips only on conflict cycles, and the first conflict after reset goes to MEM.
REQ-032 SHALL, without MEM_ARB_RR_EN, omit the pointer and use the fixed MEM priority of REQ-023.

Verification
REQ-033 SHALL cover: fetch-only read, addr 0x010, RAM returns 0xA5A5 -> out_if_valid=1 on the next cycle with out_if_word=0xA5A5, then held.
REQ-034 SHALL cover: conflict, if addr 0x020 and mem read 0x030 -> mem_gnt=1, stall=1, conflicts=1, mem_valid next cycle; without the macro fetch is granted next cycle.
REQ-035 SHALL cover: MEM write, addr 0x040 data 0x1234 -> ram_we=1, ram_wdata=0x1234, no mem_valid.
REQ-036 SHALL cover: MEM_ARB_RR_EN with 4 consecutive conflict cycles -> grants MEM, IF, MEM, IF; conflicts=4.
REQ-037 SHALL cover: reset asserted the cycle after a read grant -> valids stay 0 and conflicts=0 after release.
REQ-038 SHALL cover: CNT_WIDTH=4 with 20 conflict cycles -> out_conflicts saturates at 0xF.
